mire_gen: RTL and testbench



---
 rtl/mire_gen.sv | 150 +++++++++++++++
 tb/tb_mire_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mire_gen.sv
// mire_gen : registered test-pattern generator for the video pipeline.
//
// Produces one RGB pixel per clock, one cycle after the spot coordinates
// are presented. Four patterns are available: vertical bars, horizontal
// bars, checkerboard and horizontally scrolling bars. The pattern
// selection and the scroll offset only change on frame_start.
//
// Ports:
//   clk          pixel clock
//   reset_n      asynchronous, active-low reset
//   spotX/spotY  signed current pixel column / line
//   frame_start  single-cycle pulse at the start of each frame
//   mode_sel     requested pattern (0 vbars, 1 hbars, 2 checker, 3 scroll)
//   freeze       holds the scroll offset while high
//   pix_r/g/b    registered pixel colour
//   active_mode  pattern currently in use
module mire_gen #(
    parameter int HACTIVE     = 800,
    parameter int VACTIVE     = 600,
    parameter int NBARS       = 8,
    parameter int SQ_LOG2     = 4,
    parameter int SCROLL_STEP = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [10:0] spotX,
    input  logic signed [10:0] spotY,
    input  logic               frame_start,
    input  logic [1:0]         mode_sel,
    input  logic               freeze,
    output logic [7:0]         pix_r,
    output logic [7:0]         pix_g,
    output logic [7:0]         pix_b,
    output logic [1:0]         active_mode
);

    localparam int          OFF_W = $clog2(HACTIVE);
    localparam int unsigned H_U   = HACTIVE;
    localparam int unsigned V_U   = VACTIVE;
    localparam int unsigned BAR_W = HACTIVE / NBARS;
    localparam int unsigned BAR_H = VACTIVE / NBARS;
    localparam int unsigned LAST  = NBARS - 1;

    typedef enum logic [1:0] {
        MODE_VBARS   = 2'd0,
        MODE_HBARS   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SCROLL  = 2'd3
    } mode_t;

    mode_t            cur_mode, mode_next;
    logic [OFF_W-1:0] offset, offset_next;

    int unsigned x_u, y_u, x_eff, offset_u;
    logic        in_area;
    logic [23:0] rgb;

    function automatic logic [23:0] palette(input int unsigned idx);
        logic [23:0] c;
        case (idx % 32'd8)
            32'd0:   c = 24'hFF0000;
            32'd1:   c = 24'h00FF00;
            32'd2:   c = 24'h0000FF;
            32'd3:   c = 24'hFF00FF;
            32'd4:   c = 24'hFFFF00;
            32'd5:   c = 24'h00FFFF;
            32'd6:   c = 24'h000000;
            default: c = 24'hFFFFFF;
        endcase
        return c;
    endfunction

    // Remainder pixels beyond the last full bar are absorbed by the last bar.
    function automatic int unsigned bar_of(input int unsigned v, input int unsigned w);
        int unsigned idx;
        idx = v / w;
        if (idx > LAST) begin
            idx = LAST;
        end
        return idx;
    endfunction

    // Frame-boundary update of the pattern and scroll offset. Entering
    // scroll mode restarts the scroll from zero, even when frozen.
    // The wrap is done by comparing against HACTIVE-SCROLL_STEP so the
    // arithmetic never needs a bit wider than the offset itself.
    always_comb begin
        mode_next   = cur_mode;
        offset_next = offset;
        if (frame_start) begin
            mode_next = mode_t'(mode_sel);
            if (mode_next == MODE_SCROLL && cur_mode != MODE_SCROLL) begin
                offset_next = '0;
            end else if (!freeze) begin
                if (offset >= OFF_W'(HACTIVE - SCROLL_STEP)) begin
                    offset_next = offset - OFF_W'(HACTIVE - SCROLL_STEP);
                end else begin
                    offset_next = offset + OFF_W'(SCROLL_STEP);
                end
            end
        end
    end

    // Pixel colour for the current spot, using the pattern and offset as
    // they stand before any frame_start update in this cycle.
    always_comb begin
        x_u      = {21'd0, spotX};
        y_u      = {21'd0, spotY};
        offset_u = {{(32-OFF_W){1'b0}}, offset};
        in_area  = !spotX[10] && !spotY[10] && (x_u < H_U) && (y_u < V_U);
        x_eff    = x_u + offset_u;
        if (x_eff >= H_U) begin
            x_eff = x_eff - H_U;
        end
        case (cur_mode)
            MODE_VBARS:  rgb = palette(bar_of(x_u, BAR_W));
            MODE_HBARS:  rgb = palette(bar_of(y_u, BAR_H));
            MODE_CHECKER: begin
                if ((((x_u >> SQ_LOG2) ^ (y_u >> SQ_LOG2)) & 32'd1) == 32'd0) begin
                    rgb = 24'hFFFFFF;
                end else begin
                    rgb = 24'h000000;
                end
            end
            default:     rgb = palette(bar_of(x_eff, BAR_W));
        endcase
        if (!in_area) begin
            rgb = 24'h000000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_mode <= MODE_VBARS;
            offset   <= '0;
            pix_r    <= 8'd0;
            pix_g    <= 8'd0;
            pix_b    <= 8'd0;
        end else begin
            cur_mode <= mode_next;
            offset   <= offset_next;
            pix_r    <= rgb[23:16];
            pix_g    <= rgb[15:8];
            pix_b    <= rgb[7:0];
        end
    end

    assign active_mode = cur_mode;

endmodule

// File: tb/tb_mire_gen.sv
// tb_mire_gen : self-checking bench for mire_gen with default parameters.
// Expected pixels are pushed to a queue as each coordinate is driven and
// popped once the registered output is valid.
module tb_mire_gen;

    localparam int HACTIVE = 800;
    localparam int VACTIVE = 600;
    localparam int NBARS   = 8;
    localparam int SQ_LOG2 = 4;
    localparam int STEP    = 4;

    logic               clk;
    logic               reset_n;
    logic signed [10:0] spotX;
    logic signed [10:0] spotY;
    logic               frame_start;
    logic [1:0]         mode_sel;
    logic               freeze;
    logic [7:0]         pix_r, pix_g, pix_b;
    logic [1:0]         active_mode;

    int          n_compared;
    int          n_mismatched;
    int          m_mode;
    int          m_off;
    logic [23:0] exp_q[$];

    mire_gen #(
        .HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .NBARS(NBARS),
        .SQ_LOG2(SQ_LOG2), .SCROLL_STEP(STEP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .spotX(spotX), .spotY(spotY),
        .frame_start(frame_start), .mode_sel(mode_sel), .freeze(freeze),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .active_mode(active_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] color(input int i);
        logic [23:0] pal [8];
        pal = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF00FF,
                24'hFFFF00, 24'h00FFFF, 24'h000000, 24'hFFFFFF};
        return pal[i % 8];
    endfunction

    function automatic logic [23:0] model_pix(input int x, input int y, input int mode, input int off);
        int bar;
        int w;
        int ex;
        if (x < 0 || x >= HACTIVE || y < 0 || y >= VACTIVE) return 24'h000000;
        w = HACTIVE / NBARS;
        case (mode)
            0: bar = x / w;
            1: bar = y / (VACTIVE / NBARS);
            2: return ((((x / (1 << SQ_LOG2)) + (y / (1 << SQ_LOG2))) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: begin
                ex  = (x + off) % HACTIVE;
                bar = ex / w;
            end
        endcase
        if (bar >= NBARS) bar = NBARS - 1;
        return color(bar);
    endfunction

    // Drives one coordinate, queues the model's expectation and returns
    // just after the edge that registers it.
    task automatic send_pix(input int x, input int y);
        @(negedge clk);
        spotX = 11'(x);
        spotY = 11'(y);
        exp_q.push_back(model_pix(x, y, m_mode, m_off));
        @(posedge clk);
        #1;
    endtask

    task automatic send_exp(input int x, input int y, input logic [23:0] e);
        @(negedge clk);
        spotX = 11'(x);
        spotY = 11'(y);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input int sel, input logic frz);
        @(negedge clk);
        mode_sel    = 2'(sel);
        freeze      = frz;
        frame_start = 1'b1;
        if (sel == 3 && m_mode != 3) m_off = 0;
        else if (!frz) m_off = (m_off + STEP) % HACTIVE;
        m_mode = sel;
        @(negedge clk);
        frame_start = 1'b0;
        freeze      = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; spotX = '0; spotY = '0; frame_start = 1'b0;
        mode_sel = 2'd0; freeze = 1'b0;
        m_mode = 0; m_off = 0;
        #3 reset_n = 1'b0;
        #1;
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== 24'h000000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_pix: got %06h expected 000000", {pix_r, pix_g, pix_b});
        end
        n_compared++;
        if (active_mode !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mode: got %0d expected 0", active_mode);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_vbars();
        int          xs [7] = '{50, 99, 100, 650, 799, 800, -1};
        logic [23:0] es [7] = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h000000,
                                24'hFFFFFF, 24'h000000, 24'h000000};
        logic [23:0] e;
        for (int i = 0; i < 7; i++) begin
            send_exp(xs[i], 10, es[i]);
            e = exp_q.pop_front();
            n_compared++;
            if ({pix_r, pix_g, pix_b} !== e) begin
                n_mismatched++;
                $display("[TB] FAIL vbars x=%0d: got %06h expected %06h", xs[i], {pix_r, pix_g, pix_b}, e);
            end
        end
    endtask

    task automatic test_mode_defer();
        int          xs [4] = '{0, 16, 16, 15};
        int          ys [4] = '{0, 0, 16, 0};
        logic [23:0] es [4] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
        logic [23:0] e;
        @(negedge clk);
        mode_sel = 2'd2;
        send_exp(100, 10, 24'h00FF00);
        e = exp_q.pop_front();
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== e || active_mode !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL defer: got %06h mode %0d expected %06h mode 0", {pix_r, pix_g, pix_b}, active_mode, e);
        end
        pulse_frame(2, 1'b0);
        n_compared++;
        if (active_mode !== 2'd2) begin
            n_mismatched++;
            $display("[TB] FAIL checker_mode: got %0d expected 2", active_mode);
        end
        for (int i = 0; i < 4; i++) begin
            send_exp(xs[i], ys[i], es[i]);
            e = exp_q.pop_front();
            n_compared++;
            if ({pix_r, pix_g, pix_b} !== e) begin
                n_mismatched++;
                $display("[TB] FAIL checker (%0d,%0d): got %06h expected %06h", xs[i], ys[i], {pix_r, pix_g, pix_b}, e);
            end
        end
    endtask

    task automatic test_hbars();
        int          ys [4] = '{74, 75, 600, 599};
        logic [23:0] es [4] = '{24'hFF0000, 24'h00FF00, 24'h000000, 24'hFFFFFF};
        logic [23:0] e;
        pulse_frame(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_exp(10, ys[i], es[i]);
            e = exp_q.pop_front();
            n_compared++;
            if ({pix_r, pix_g, pix_b} !== e) begin
                n_mismatched++;
                $display("[TB] FAIL hbars y=%0d: got %06h expected %06h", ys[i], {pix_r, pix_g, pix_b}, e);
            end
        end
    endtask

    task automatic test_scroll();
        int          xs [4] = '{0, 750, 699, 700};
        logic [23:0] es [4] = '{24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'hFF0000};
        logic [23:0] e;
        pulse_frame(3, 1'b0);
        send_exp(0, 20, 24'hFF0000);
        e = exp_q.pop_front();
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== e) begin
            n_mismatched++;
            $display("[TB] FAIL scroll_entry: got %06h expected %06h", {pix_r, pix_g, pix_b}, e);
        end
        repeat (25) pulse_frame(3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_exp(xs[i], 20, es[i]);
            e = exp_q.pop_front();
            n_compared++;
            if ({pix_r, pix_g, pix_b} !== e) begin
                n_mismatched++;
                $display("[TB] FAIL scroll100 x=%0d: got %06h expected %06h", xs[i], {pix_r, pix_g, pix_b}, e);
            end
        end
        repeat (175) pulse_frame(3, 1'b0);
        send_exp(799, 20, 24'hFFFFFF);
        e = exp_q.pop_front();
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== e) begin
            n_mismatched++;
            $display("[TB] FAIL scroll_wrap0: got %06h expected %06h", {pix_r, pix_g, pix_b}, e);
        end
    endtask

    task automatic test_freeze();
        logic [23:0] e;
        repeat (50) pulse_frame(3, 1'b0);
        for (int f = 0; f < 5; f++) begin
            pulse_frame(3, 1'b1);
            send_exp(650, 30, 24'hFF0000);
            e = exp_q.pop_front();
            n_compared++;
            if ({pix_r, pix_g, pix_b} !== e) begin
                n_mismatched++;
                $display("[TB] FAIL freeze frame %0d: got %06h expected %06h", f, {pix_r, pix_g, pix_b}, e);
            end
        end
        pulse_frame(3, 1'b0);
        send_exp(596, 30, 24'hFF0000);
        e = exp_q.pop_front();
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== e) begin
            n_mismatched++;
            $display("[TB] FAIL unfreeze: got %06h expected %06h", {pix_r, pix_g, pix_b}, e);
        end
        pulse_frame(0, 1'b1);
        pulse_frame(3, 1'b1);
        send_exp(0, 30, 24'hFF0000);
        e = exp_q.pop_front();
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== e || active_mode !== 2'd3) begin
            n_mismatched++;
            $display("[TB] FAIL enter_scroll_frozen: got %06h mode %0d expected %06h mode 3", {pix_r, pix_g, pix_b}, active_mode, e);
        end
    endtask

    task automatic test_back_to_back();
        int          x, y;
        logic [23:0] e;
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(815)) - 5;
            y = int'($urandom_range(610)) - 5;
            send_pix(x, y);
            e = exp_q.pop_front();
            n_compared++;
            if ({pix_r, pix_g, pix_b} !== e) begin
                n_mismatched++;
                $display("[TB] FAIL stream (%0d,%0d) off %0d: got %06h expected %06h", x, y, m_off, {pix_r, pix_g, pix_b}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [23:0] e;
        while (m_off != 200) pulse_frame(3, 1'b0);
        send_exp(650, 40, 24'hFF0000);
        e = exp_q.pop_front();
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== e) begin
            n_mismatched++;
            $display("[TB] FAIL pre_reset: got %06h expected %06h", {pix_r, pix_g, pix_b}, e);
        end
        #2 reset_n = 1'b0;
        #1;
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== 24'h000000 || active_mode !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: got %06h mode %0d expected 000000 mode 0", {pix_r, pix_g, pix_b}, active_mode);
        end
        m_mode = 0;
        m_off  = 0;
        @(negedge clk);
        reset_n = 1'b1;
        send_exp(0, 40, 24'hFF0000);
        e = exp_q.pop_front();
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== e || active_mode !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset: got %06h mode %0d expected %06h mode 0", {pix_r, pix_g, pix_b}, active_mode, e);
        end
        send_pix(150, 40);
        e = exp_q.pop_front();
        n_compared++;
        if ({pix_r, pix_g, pix_b} !== e) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_bar1: got %06h expected %06h", {pix_r, pix_g, pix_b}, e);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_vbars();
        test_mode_defer();
        test_hbars();
        test_scroll();
        test_freeze();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
